// File: rtl/flash_seq.sv
// SPI-flash command sequencer: opcode, 0..3 address bytes, then LEN data bytes,
// paced one byte per shifter slot, with chip-select setup/hold and abort handling.
module flash_seq #(
  parameter int BYTE_CYCLES = 16,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int LEN_W       = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       opcode,
  input  logic [23:0]      addr,
  input  logic [1:0]       naddr,
  input  logic [LEN_W-1:0] len,
  input  logic             dir,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             fws,
  output logic             frs,
  output logic [7:0]       fdata_o,
  input  logic [7:0]       fdata_i,
  output logic             fcs
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_HOLD} state_t;

  localparam int TW = $clog2(BYTE_CYCLES + CS_HOLD + CS_SETUP + 1) + 1;
  localparam logic [TW-1:0] T_MAX   = '1;
  localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] T_READY = TW'(BYTE_CYCLES - 2);
  localparam logic [TW-1:0] T_SLOT  = TW'(BYTE_CYCLES - 1);
  localparam logic [TW-1:0] T_DONE  = TW'(BYTE_CYCLES);
  localparam logic [TW-1:0] T_END   = TW'(BYTE_CYCLES + CS_HOLD - 1);

  state_t           state;
  logic [TW-1:0]    tmr;        // cycles since the last byte strobe, saturating
  logic [7:0]       opcode_q;
  logic [23:0]      addr_sr;
  logic [1:0]       addr_left;
  logic [LEN_W-1:0] len_left;
  logic             dir_q;
  logic             rd_pend;
  logic             abort_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tmr        <= '0;
      opcode_q   <= '0;
      addr_sr    <= '0;
      addr_left  <= '0;
      len_left   <= '0;
      dir_q      <= 1'b0;
      rd_pend    <= 1'b0;
      abort_seen <= 1'b0;
      wr_ready   <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      fws        <= 1'b0;
      frs        <= 1'b0;
      fdata_o    <= '0;
      fcs        <= 1'b1;
    end else begin
      // NOTE: strobes default low here so every pulse below lasts exactly one cycle.
      fws      <= 1'b0;
      frs      <= 1'b0;
      done     <= 1'b0;
      rd_valid <= frs;
      if (frs) rd_data <= fdata_i;
      if (tmr != T_MAX) tmr <= tmr + TW'(1);

      // A read slot finishes on its own, even after an abort has moved us to HOLD.
      if (rd_pend && tmr == T_SLOT) begin
        frs     <= 1'b1;
        rd_pend <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            opcode_q   <= opcode;
            len_left   <= len;
            dir_q      <= dir;
            addr_left  <= naddr;
            case (naddr)
              2'd1:    addr_sr <= {addr[7:0], 16'h0000};
              2'd2:    addr_sr <= {addr[15:0], 8'h00};
              default: addr_sr <= addr;
            endcase
            aborted    <= 1'b0;
            abort_seen <= 1'b0;
            busy       <= 1'b1;
            fcs        <= 1'b0;
            tmr        <= '0;
            state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (abort) begin
            abort_seen <= 1'b1;
            tmr        <= T_DONE;
            state      <= S_HOLD;
          end else if (tmr == T_SETUP) begin
            fws     <= 1'b1;
            fdata_o <= opcode_q;
            tmr     <= '0;
            state   <= S_CMD;
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (abort) begin
            abort_seen <= 1'b1;
            wr_ready   <= 1'b0;
            state      <= S_HOLD;
            // Stalled on write data: the last slot is already over.
            if (wr_ready) tmr <= T_DONE;
          end else if (state == S_DATA && !dir_q) begin
            if (wr_ready) begin
              if (wr_valid) begin
                fws      <= 1'b1;
                fdata_o  <= wr_data;
                tmr      <= '0;
                len_left <= len_left - LEN_W'(1);
                wr_ready <= 1'b0;
              end
            end else if (tmr == T_READY) begin
              if (len_left != '0) wr_ready <= 1'b1;
              else                state    <= S_HOLD;
            end
          end else if (addr_left == 2'd0 && len_left != '0 && !dir_q) begin
            // Open the write handshake one cycle early so data can strobe on the slot boundary.
            if (tmr == T_READY) begin
              wr_ready <= 1'b1;
              state    <= S_DATA;
            end
          end else if (tmr == T_SLOT) begin
            if (addr_left != 2'd0) begin
              fws       <= 1'b1;
              fdata_o   <= addr_sr[23:16];
              addr_sr   <= {addr_sr[15:0], 8'h00};
              addr_left <= addr_left - 2'd1;
              tmr       <= '0;
              state     <= S_ADDR;
            end else if (len_left != '0) begin
              fws      <= 1'b1;
              fdata_o  <= 8'hFF;
              rd_pend  <= 1'b1;
              len_left <= len_left - LEN_W'(1);
              tmr      <= '0;
              state    <= S_DATA;
            end else begin
              state <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (tmr == T_END) begin
            fcs     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= abort_seen;
            state   <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq: cycle-accurate strobe timing for read, write,
// stall, abort, reset and back-to-back transactions.
module tb_flash_seq;

  logic       clk = 1'b0;
  logic       reset, start, abort, dir, wr_valid;
  logic [7:0] opcode, wr_data, fdata_i;
  logic [23:0] addr;
  logic [1:0] naddr;
  logic [8:0] len;
  logic       wr_ready, rd_valid, busy, done, aborted, fws, frs, fcs;
  logic [7:0] rd_data, fdata_o;

  flash_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .opcode(opcode),
    .addr(addr), .naddr(naddr), .len(len), .dir(dir), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .aborted(aborted),
    .fws(fws), .frs(frs), .fdata_o(fdata_o), .fdata_i(fdata_i), .fcs(fcs)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int         fws_cyc[$];
  logic [7:0] fws_dat[$];
  int         frs_cyc[$];
  int         rdv_cyc[$];
  logic [7:0] rdv_dat[$];
  int         done_cyc[$];
  int         wrr_first;
  logic       fcs_log[0:299];
  logic       busy_log[0:299];
  logic       abt_log[0:299];

  // Cycle c is the interval after the c-th rising edge following the START drive.
  task automatic run(input logic [7:0] op, input logic [23:0] ad, input logic [1:0] na,
                     input logic [8:0] ln, input logic dr, input logic [23:0] wd,
                     input int ncyc, input int abort_at, input int reset_at,
                     input int restart_at, input int extra_at, input int wv_mode,
                     input int wv_from);
    int wi;
    wi = 0;
    fws_cyc.delete(); fws_dat.delete(); frs_cyc.delete();
    rdv_cyc.delete(); rdv_dat.delete(); done_cyc.delete();
    wrr_first = -1;
    for (int c = 0; c < ncyc; c++) begin
      start    = (c == 0) || (c == restart_at) || (c == extra_at);
      opcode   = (c == extra_at) ? 8'h9F : op;
      addr     = ad;
      naddr    = na;
      len      = ln;
      dir      = dr;
      abort    = (c == abort_at);
      reset    = (c == reset_at);
      fdata_i  = 8'(c + 16);
      wr_valid = (wv_mode == 0) ? (c >= wv_from) : ((c % 7) >= 4);
      wr_data  = 8'(wd >> (16 - 8 * wi));
      @(negedge clk);
      if (fws) begin fws_cyc.push_back(c); fws_dat.push_back(fdata_o); end
      if (frs) frs_cyc.push_back(c);
      if (rd_valid) begin rdv_cyc.push_back(c); rdv_dat.push_back(rd_data); end
      if (done) done_cyc.push_back(c);
      if (wr_ready && wrr_first < 0) wrr_first = c;
      fcs_log[c]  = fcs;
      busy_log[c] = busy;
      abt_log[c]  = aborted;
      if (wr_valid && wr_ready && wi < 2) wi++;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0;
    opcode = '0; addr = '0; naddr = '0; len = '0; dir = 1'b0; wr_data = '0; fdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({fcs, busy, done, aborted, fws, frs, rd_valid, wr_ready} !== 8'b1000_0000) begin
      $display("FAIL reset_ctrl: got %b want 10000000", {fcs, busy, done, aborted, fws, frs, rd_valid, wr_ready});
      n_fail++;
    end
    n_chk++;
    if ({rd_data, fdata_o} !== 16'h0000) begin
      $display("FAIL reset_data: got %h want 0000", {rd_data, fdata_o});
      n_fail++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int         ec[6] = '{3, 19, 35, 51, 67, 83};
    logic [7:0] ed[6] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF};
    int low_bad;
    run(8'h03, 24'h012345, 2'd3, 9'd2, 1'b1, 24'h0, 110, -1, -1, -1, 50, 0, 1000);
    n_chk++;
    if (fws_cyc.size() !== 6) begin $display("FAIL read_fws_count: got %0d want 6", fws_cyc.size()); n_fail++; end
    for (int i = 0; i < 6 && i < fws_cyc.size(); i++) begin
      n_chk++;
      if (fws_cyc[i] !== ec[i] || fws_dat[i] !== ed[i]) begin
        $display("FAIL read_fws[%0d]: got cyc %0d data %h want cyc %0d data %h", i, fws_cyc[i], fws_dat[i], ec[i], ed[i]);
        n_fail++;
      end
    end
    n_chk++;
    if (frs_cyc.size() !== 2 || frs_cyc[0] !== 83 || frs_cyc[1] !== 99) begin
      $display("FAIL read_frs: got %p want 83,99", frs_cyc); n_fail++;
    end
    n_chk++;
    if (rdv_cyc.size() !== 2 || rdv_cyc[0] !== 84 || rdv_cyc[1] !== 100 ||
        rdv_dat[0] !== 8'h63 || rdv_dat[1] !== 8'h73) begin
      $display("FAIL read_rdvalid: got cyc %p data %p want 84,100 data 63,73", rdv_cyc, rdv_dat); n_fail++;
    end
    low_bad = 0;
    for (int c = 1; c <= 100; c++) if (fcs_log[c] !== 1'b0) low_bad++;
    n_chk++;
    if (low_bad !== 0 || fcs_log[101] !== 1'b1) begin
      $display("FAIL read_fcs: got %0d high cycles in 1..100, fcs@101=%b want 0 and 1", low_bad, fcs_log[101]); n_fail++;
    end
    n_chk++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 101 || busy_log[100] !== 1'b1 || busy_log[101] !== 1'b0) begin
      $display("FAIL read_done: got done %p busy@100=%b busy@101=%b want 101,1,0", done_cyc, busy_log[100], busy_log[101]); n_fail++;
    end
  endtask

  task automatic test_opcode_only();
    run(8'h06, 24'h0, 2'd0, 9'd0, 1'b0, 24'h0, 24, -1, -1, -1, -1, 0, 0);
    n_chk++;
    if (fws_cyc.size() !== 1 || fws_cyc[0] !== 3 || fws_dat[0] !== 8'h06) begin
      $display("FAIL opc_fws: got cyc %p data %p want 3 data 06", fws_cyc, fws_dat); n_fail++;
    end
    n_chk++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 21 || fcs_log[20] !== 1'b0 || fcs_log[21] !== 1'b1) begin
      $display("FAIL opc_end: got done %p fcs@20=%b fcs@21=%b want 21,0,1", done_cyc, fcs_log[20], fcs_log[21]); n_fail++;
    end
    n_chk++;
    if (wrr_first !== -1) begin $display("FAIL opc_wr_ready: got %0d want -1", wrr_first); n_fail++; end
  endtask

  task automatic test_write_stall();
    int         ec[6] = '{3, 19, 35, 51, 101, 117};
    logic [7:0] ed[6] = '{8'h02, 8'h01, 8'h23, 8'h45, 8'hAA, 8'h55};
    run(8'h02, 24'h012345, 2'd3, 9'd2, 1'b0, 24'hAA5500, 140, -1, -1, -1, -1, 0, 100);
    n_chk++;
    if (wrr_first !== 66) begin $display("FAIL stall_wr_ready: got %0d want 66", wrr_first); n_fail++; end
    n_chk++;
    if (fws_cyc.size() !== 6) begin $display("FAIL stall_fws_count: got %0d want 6", fws_cyc.size()); n_fail++; end
    for (int i = 0; i < 6 && i < fws_cyc.size(); i++) begin
      n_chk++;
      if (fws_cyc[i] !== ec[i] || fws_dat[i] !== ed[i]) begin
        $display("FAIL stall_fws[%0d]: got cyc %0d data %h want cyc %0d data %h", i, fws_cyc[i], fws_dat[i], ec[i], ed[i]);
        n_fail++;
      end
    end
    n_chk++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 135 || fcs_log[134] !== 1'b0 || fcs_log[135] !== 1'b1) begin
      $display("FAIL stall_end: got done %p fcs@134=%b fcs@135=%b want 135,0,1", done_cyc, fcs_log[134], fcs_log[135]); n_fail++;
    end
  endtask

  task automatic test_write_gaps();
    int         ec[5] = '{3, 19, 35, 54, 70};
    logic [7:0] ed[5] = '{8'h02, 8'h45, 8'hAA, 8'h55, 8'hC3};
    int close;
    run(8'h02, 24'h012345, 2'd1, 9'd3, 1'b0, 24'hAA55C3, 95, -1, -1, -1, 60, 1, 0);
    n_chk++;
    if (fws_cyc.size() !== 5) begin $display("FAIL gap_fws_count: got %0d want 5", fws_cyc.size()); n_fail++; end
    for (int i = 0; i < 5 && i < fws_cyc.size(); i++) begin
      n_chk++;
      if (fws_cyc[i] !== ec[i] || fws_dat[i] !== ed[i]) begin
        $display("FAIL gap_fws[%0d]: got cyc %0d data %h want cyc %0d data %h", i, fws_cyc[i], fws_dat[i], ec[i], ed[i]);
        n_fail++;
      end
    end
    close = 0;
    for (int i = 1; i < fws_cyc.size(); i++) if (fws_cyc[i] - fws_cyc[i-1] < 16) close++;
    n_chk++;
    if (close !== 0) begin $display("FAIL gap_spacing: got %0d close pairs want 0", close); n_fail++; end
    n_chk++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 88) begin
      $display("FAIL gap_done: got %p want 88", done_cyc); n_fail++;
    end
  endtask

  task automatic test_abort();
    run(8'h03, 24'h012345, 2'd3, 9'd2, 1'b1, 24'h0, 60, 40, -1, -1, -1, 0, 1000);
    n_chk++;
    if (fws_cyc.size() !== 3 || fws_cyc[2] !== 35) begin
      $display("FAIL abort_fws: got %p want 3,19,35", fws_cyc); n_fail++;
    end
    n_chk++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 53 || fcs_log[52] !== 1'b0 || fcs_log[53] !== 1'b1) begin
      $display("FAIL abort_end: got done %p fcs@52=%b fcs@53=%b want 53,0,1", done_cyc, fcs_log[52], fcs_log[53]); n_fail++;
    end
    n_chk++;
    if (abt_log[52] !== 1'b0 || abt_log[53] !== 1'b1 || frs_cyc.size() !== 0) begin
      $display("FAIL abort_flag: got aborted@52=%b @53=%b frs=%0d want 0,1,0", abt_log[52], abt_log[53], frs_cyc.size()); n_fail++;
    end
    run(8'h06, 24'h0, 2'd0, 9'd0, 1'b0, 24'h0, 22, -1, -1, -1, -1, 0, 0);
    n_chk++;
    if (abt_log[0] !== 1'b1 || abt_log[1] !== 1'b0) begin
      $display("FAIL abort_clear: got aborted@0=%b @1=%b want 1,0", abt_log[0], abt_log[1]); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int         ec[8] = '{3, 19, 35, 51, 67, 83, 99, 115};
    logic [7:0] ed[8] = '{8'h03, 8'h01, 8'h03, 8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF};
    run(8'h03, 24'h012345, 2'd3, 9'd2, 1'b1, 24'h0, 140, -1, 30, 32, -1, 0, 1000);
    n_chk++;
    if (fcs_log[31] !== 1'b1 || busy_log[31] !== 1'b0) begin
      $display("FAIL rstmid_idle: got fcs@31=%b busy@31=%b want 1,0", fcs_log[31], busy_log[31]); n_fail++;
    end
    n_chk++;
    if (fws_cyc.size() !== 8) begin $display("FAIL rstmid_fws_count: got %0d want 8", fws_cyc.size()); n_fail++; end
    for (int i = 0; i < 8 && i < fws_cyc.size(); i++) begin
      n_chk++;
      if (fws_cyc[i] !== ec[i] || fws_dat[i] !== ed[i]) begin
        $display("FAIL rstmid_fws[%0d]: got cyc %0d data %h want cyc %0d data %h", i, fws_cyc[i], fws_dat[i], ec[i], ed[i]);
        n_fail++;
      end
    end
    n_chk++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 133) begin
      $display("FAIL rstmid_done: got %p want 133", done_cyc); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    run(8'h06, 24'h0, 2'd0, 9'd0, 1'b0, 24'h0, 22, -1, -1, -1, -1, 0, 0);
    run(8'hB7, 24'h0, 2'd0, 9'd0, 1'b0, 24'h0, 24, -1, -1, -1, -1, 0, 0);
    n_chk++;
    if (fws_cyc.size() !== 1 || fws_cyc[0] !== 3 || fws_dat[0] !== 8'hB7 ||
        done_cyc.size() !== 1 || done_cyc[0] !== 21) begin
      $display("FAIL b2b: got fws %p data %p done %p want 3,B7,21", fws_cyc, fws_dat, done_cyc); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_opcode_only();
    test_write_stall();
    test_write_gaps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
